lsu_seq: RTL
============

# lsu_seq

Load/store sequencer between the execute stage and the `memory` RAM block. Accepts one load or store per handshake, drives the RAM's read/write strobes, address, data and width code with the cycle timing the RAM needs, and returns sign- or zero-extended load results to writeback. Stores go to the RAM as sequential byte writes (`Wdt8`). With the misalign option compiled in, loads that cross an 8-byte boundary are split into two reads.

## Interface
- No parameters; widths come from `include/defines.v` (`RegWidth`=64, `ImmWidth`=64, `WdtTypeCnt`, `Wdt8/16/32/64`).
- `clk` in 1: single clock, all state on posedge.
- `rst` in 1: synchronous, active-high reset.
- `ex_valid` in 1: request present.
- `ex_ready` out 1: sequencer can accept (IDLE and not `rst`).
- `ex_load`, `ex_store` in 1 each: operation; both 0 or both 1 with `ex_valid` is illegal and is dropped.
- `ex_unsigned` in 1: zero-extend load result.
- `ex_wdt` in `WdtTypeCnt`: access width code.
- `ex_addr` in `RegWidth`: byte address.
- `ex_wdata` in `RegWidth`: store data, low bytes used.
- `ex_rd` in 5: destination register tag.
- `mem_ren`, `mem_wen` out 1: RAM strobes.
- `mem_raddr`, `mem_waddr` out `RegWidth`: RAM addresses.
- `mem_wdata` out `RegWidth`: RAM write data.
- `mem_wdt` out `WdtTypeCnt`: RAM width code.
- `mem_rdata` in `ImmWidth`: RAM read data, zero-extended to width.
- `wb_valid` out 1; `wb_ready` in 1; `wb_data` out 64; `wb_rd` out 5: load result handshake.
- `lsu_misalign` out 1: one-cycle fault pulse.

## Operation
- States: IDLE, RD, RD_WAIT, RD_HI, RD_HI_WAIT, ST, RESP.
- IDLE: `ex_valid && ex_ready` latches op, addr, wdata, wdt, rd, unsigned. Load goes to RD. Store goes to ST with a byte counter `n` = 1/2/4/8 by width.
- RD: `mem_ren`=1 and `mem_raddr`=A; `mem_wdt`=latched width. → RD_WAIT.
- RD_WAIT: `mem_ren`=0, `mem_raddr` held at A, because the RAM's lane mux uses the address in the data cycle. Capture `mem_rdata` at the end of the cycle. → RESP, or → RD_HI when the access is split.
- Extension: bit 7/15/31 of the captured data is replicated up to bit 63 unless unsigned. 64-bit loads pass through unchanged.
- ST: one byte per cycle. `mem_wen`=1, `mem_waddr`=A+i, `mem_wdata`={56'b0, byte i}, `mem_wdt`=`Wdt8`. Byte i is `ex_wdata[8i+7:8i]`, i=0..n-1 in ascending order. After byte n-1, go to IDLE. Stores never assert `wb_valid`.
- RESP: `wb_valid`=1 with `wb_data` and `wb_rd` held stable until `wb_ready`. On handshake → IDLE.
- Arithmetic: A+i wraps modulo 2^64. Stores are never misaligned because byte writes handle any address.
- Reset values: state IDLE; `mem_ren`, `mem_wen`, `wb_valid`, `lsu_misalign` = 0; all addresses, data and `wb_rd` = 0; `mem_wdt`=`Wdt8`.
- `rst` mid-operation: the state machine returns to IDLE at the next edge and partial stores are abandoned. `mem_wen` and `mem_ren` are combinationally gated by `rst`, so no negedge write occurs during a reset cycle.

## Timing
- Aligned load: accept at cycle 0, RD at cycle 1, RD_WAIT at cycle 2, `wb_valid` at cycle 3. Next accept is possible in the cycle after the `wb` handshake.
- Split load: two extra cycles, so `wb_valid` comes at cycle 5.
- Store of width n: `mem_wen` is high in cycles 1..n; `ex_ready` returns in cycle n+1.
- `wb_ready` held low stalls in RESP indefinitely; `ex_ready` stays 0.

## Configuration
- `LSU_MISALIGN_EN` defined: a load whose bytes span two aligned doublewords (`addr[2:0]` + size > 8) becomes two `Wdt64` reads.
  - First read: RD/RD_WAIT at `A & ~7`.
  - Second read: RD_HI/RD_HI_WAIT at `(A & ~7) + 8`.
  - Result = ({hi, lo} >> 8·`A[2:0]`), truncated to the load size, then extended.
- Undefined: a load that is not aligned to its size pulses `lsu_misalign` for one cycle at accept. No RAM access is made, nothing is written back, and the sequencer stays IDLE. The RD_HI states are not built.

## Structure
- Package `lsu_pkg`: state enum, byte-count function from width code, and the extension function.
- Sub-module `lsu_extend`: combinational lane select for split reads and sign/zero extension. The sequencer keeps all registers.

## Test plan
- Load word, `ex_addr`=0x80000004, RAM doubleword = 0x8000_0001_1234_5678, signed.
  - Required: `mem_ren` only in cycle 1, `mem_raddr` held for cycles 1–2, `wb_data`=0xFFFF_FFFF_8000_0001 at cycle 3.
- Load byte at 0x80000003 unsigned with RAM byte 0xF0.
  - Required: `wb_data`=0xF0. The same load signed gives 0xFFFF_FFFF_FFFF_FFF0.
- Store half 0xBEEF at 0x80000011.
  - Required: exactly two `Wdt8` writes: 0xEF to 0x80000011 in cycle 1, 0xBE to 0x80000012 in cycle 2. `ex_ready` returns at cycle 3.
- `wb_ready` held low for 5 cycles after a load.
  - Required: `wb_valid` stays 1 with constant `wb_data`, and a second `ex_valid` is not accepted.
- Assert `rst` during cycle 2 of an 8-byte store.
  - Required: no `mem_wen` in the reset cycle, IDLE afterwards, all outputs at reset values.
- Word load at 0x80000006.
  - With the macro: two reads at 0x80000000 and 0x80000008, merged result at cycle 5.
  - Without the macro: `lsu_misalign` pulses and there is no `mem_ren`.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store sequencer: width codes, FSM states,
// byte-count lookup and load-result extension.
package lsu_pkg;

  localparam int RegWidth   = 64;
  localparam int ImmWidth   = 64;
  localparam int WdtTypeCnt = 4;

  localparam logic [WdtTypeCnt-1:0] Wdt8  = 4'b0001;
  localparam logic [WdtTypeCnt-1:0] Wdt16 = 4'b0010;
  localparam logic [WdtTypeCnt-1:0] Wdt32 = 4'b0100;
  localparam logic [WdtTypeCnt-1:0] Wdt64 = 4'b1000;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RD         = 3'd1,
    S_RD_WAIT    = 3'd2,
    S_RD_HI      = 3'd3,
    S_RD_HI_WAIT = 3'd4,
    S_ST         = 3'd5,
    S_RESP       = 3'd6
  } lsu_state_e;

  function automatic logic [3:0] wdt_bytes(input logic [WdtTypeCnt-1:0] wdt);
    logic [3:0] n;
    case (wdt)
      Wdt8:    n = 4'd1;
      Wdt16:   n = 4'd2;
      Wdt32:   n = 4'd4;
      Wdt64:   n = 4'd8;
      default: n = 4'd1;
    endcase
    return n;
  endfunction

  function automatic logic [63:0] ext_load(input logic [63:0] d,
                                           input logic [WdtTypeCnt-1:0] wdt,
                                           input logic uns);
    logic [63:0] r;
    case (wdt)
      Wdt8:    r = uns ? {56'd0, d[7:0]}  : {{56{d[7]}},  d[7:0]};
      Wdt16:   r = uns ? {48'd0, d[15:0]} : {{48{d[15]}}, d[15:0]};
      Wdt32:   r = uns ? {32'd0, d[31:0]} : {{32{d[31]}}, d[31:0]};
      Wdt64:   r = d;
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Combinational load-result path: lane merge for split reads, then sign/zero
// extension to 64 bits.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [63:0]           i_lo,
  input  logic [63:0]           i_hi,
  input  logic [2:0]            i_off,
  input  logic                  i_split,
  input  logic [WdtTypeCnt-1:0] i_wdt,
  input  logic                  i_uns,
  output logic [63:0]           o_data
);

  logic [127:0] w_merged;
  logic [63:0]  w_lane;

  assign w_merged = {i_hi, i_lo} >> {i_off, 3'b000};

  // Pick merged lanes for a split access, otherwise the RAM already lane-muxed.
  always_comb begin
    w_lane = i_lo;
    if (i_split) begin
      w_lane = w_merged[63:0];
    end else begin
      w_lane = i_lo;
    end
    o_data = ext_load(w_lane, i_wdt, i_uns);
  end

endmodule

// File: rtl/lsu_seq.sv
// Load/store sequencer between execute and the RAM block. Define LSU_MISALIGN_EN
// to split doubleword-crossing loads into two reads; otherwise they fault.
module lsu_seq
  import lsu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic                  ex_load,
  input  logic                  ex_store,
  input  logic                  ex_unsigned,
  input  logic [WdtTypeCnt-1:0] ex_wdt,
  input  logic [RegWidth-1:0]   ex_addr,
  input  logic [RegWidth-1:0]   ex_wdata,
  input  logic [4:0]            ex_rd,
  output logic                  mem_ren,
  output logic                  mem_wen,
  output logic [RegWidth-1:0]   mem_raddr,
  output logic [RegWidth-1:0]   mem_waddr,
  output logic [RegWidth-1:0]   mem_wdata,
  output logic [WdtTypeCnt-1:0] mem_wdt,
  input  logic [ImmWidth-1:0]   mem_rdata,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [63:0]           wb_data,
  output logic [4:0]            wb_rd,
  output logic                  lsu_misalign
);

  lsu_state_e            r_state;
  logic                  r_mem_ren;
  logic                  r_mem_wen;
  logic [RegWidth-1:0]   r_mem_raddr;
  logic [RegWidth-1:0]   r_mem_waddr;
  logic [RegWidth-1:0]   r_mem_wdata;
  logic [WdtTypeCnt-1:0] r_mem_wdt;
  logic                  r_wb_valid;
  logic [63:0]           r_wb_data;
  logic [4:0]            r_wb_rd;
  logic                  r_misalign;
  logic [WdtTypeCnt-1:0] r_wdt;
  logic                  r_uns;
  logic [RegWidth-1:0]   r_addr;
  logic [RegWidth-1:0]   r_wdata;
  logic [2:0]            r_cnt;
  logic [3:0]            r_n;

  logic [3:0]  w_bytes;
  logic        w_legal;
  logic        w_accept;
  logic        w_split_req;
  logic        w_fault;
  logic [2:0]  w_next;
  logic [63:0] w_ext;
  logic [63:0] w_ext_lo;
  logic [63:0] w_ext_hi;
  logic [2:0]  w_ext_off;
  logic        w_ext_split;

  assign w_bytes  = wdt_bytes(ex_wdt);
  assign w_legal  = ex_load ^ ex_store;
  assign ex_ready = (r_state == S_IDLE) && !rst;
  assign w_accept = ex_valid && ex_ready;
  assign w_next   = r_cnt + 3'd1;

`ifdef LSU_MISALIGN_EN
  logic        r_split;
  logic [2:0]  r_off;
  logic [63:0] r_lo;

  assign w_split_req = ({1'b0, ex_addr[2:0]} + w_bytes) > 4'd8;
  assign w_fault     = 1'b0;
  assign w_ext_lo    = r_split ? r_lo : mem_rdata;
  assign w_ext_hi    = mem_rdata;
  assign w_ext_off   = r_off;
  assign w_ext_split = r_split;
`else
  assign w_split_req = 1'b0;
  assign w_fault     = ({1'b0, ex_addr[2:0]} & (w_bytes - 4'd1)) != 4'd0;
  assign w_ext_lo    = mem_rdata;
  assign w_ext_hi    = 64'd0;
  assign w_ext_off   = 3'd0;
  assign w_ext_split = 1'b0;
`endif

  lsu_extend u_extend (
    .i_lo    (w_ext_lo),
    .i_hi    (w_ext_hi),
    .i_off   (w_ext_off),
    .i_split (w_ext_split),
    .i_wdt   (r_wdt),
    .i_uns   (r_uns),
    .o_data  (w_ext)
  );

  // Strobes are gated by rst so a reset cycle never reaches the RAM.
  assign mem_ren      = r_mem_ren & ~rst;
  assign mem_wen      = r_mem_wen & ~rst;
  assign mem_raddr    = r_mem_raddr;
  assign mem_waddr    = r_mem_waddr;
  assign mem_wdata    = r_mem_wdata;
  assign mem_wdt      = r_mem_wdt;
  assign wb_valid     = r_wb_valid;
  assign wb_data      = r_wb_data;
  assign wb_rd        = r_wb_rd;
  assign lsu_misalign = r_misalign;

  // Sequencer FSM with registered RAM and writeback outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_mem_ren   <= 1'b0;
      r_mem_wen   <= 1'b0;
      r_mem_raddr <= 64'd0;
      r_mem_waddr <= 64'd0;
      r_mem_wdata <= 64'd0;
      r_mem_wdt   <= Wdt8;
      r_wb_valid  <= 1'b0;
      r_wb_data   <= 64'd0;
      r_wb_rd     <= 5'd0;
      r_misalign  <= 1'b0;
      r_wdt       <= Wdt8;
      r_uns       <= 1'b0;
      r_addr      <= 64'd0;
      r_wdata     <= 64'd0;
      r_cnt       <= 3'd0;
      r_n         <= 4'd0;
`ifdef LSU_MISALIGN_EN
      r_split     <= 1'b0;
      r_off       <= 3'd0;
      r_lo        <= 64'd0;
`endif
    end else begin
      r_misalign <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_legal) begin
            r_wdt <= ex_wdt;
            r_uns <= ex_unsigned;
            if (ex_load) begin
              if (w_fault) begin
                r_misalign <= 1'b1;
              end else begin
                r_state     <= S_RD;
                r_mem_ren   <= 1'b1;
                r_mem_raddr <= w_split_req ? {ex_addr[63:3], 3'b000} : ex_addr;
                r_mem_wdt   <= w_split_req ? Wdt64 : ex_wdt;
                r_wb_rd     <= ex_rd;
`ifdef LSU_MISALIGN_EN
                r_split     <= w_split_req;
                r_off       <= ex_addr[2:0];
`endif
              end
            end else begin
              r_state     <= S_ST;
              r_mem_wen   <= 1'b1;
              r_mem_waddr <= ex_addr;
              r_mem_wdata <= {56'd0, ex_wdata[7:0]};
              r_mem_wdt   <= Wdt8;
              r_addr      <= ex_addr;
              r_wdata     <= ex_wdata;
              r_cnt       <= 3'd0;
              r_n         <= w_bytes;
            end
          end
        end
        S_RD: begin
          r_mem_ren <= 1'b0;
          r_state   <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
`ifdef LSU_MISALIGN_EN
          if (r_split) begin
            r_lo        <= mem_rdata;
            r_mem_ren   <= 1'b1;
            r_mem_raddr <= r_mem_raddr + 64'd8;
            r_state     <= S_RD_HI;
          end else begin
            r_wb_data  <= w_ext;
            r_wb_valid <= 1'b1;
            r_state    <= S_RESP;
          end
`else
          r_wb_data  <= w_ext;
          r_wb_valid <= 1'b1;
          r_state    <= S_RESP;
`endif
        end
`ifdef LSU_MISALIGN_EN
        S_RD_HI: begin
          r_mem_ren <= 1'b0;
          r_state   <= S_RD_HI_WAIT;
        end
        S_RD_HI_WAIT: begin
          r_wb_data  <= w_ext;
          r_wb_valid <= 1'b1;
          r_state    <= S_RESP;
        end
`endif
        S_ST: begin
          if ({1'b0, r_cnt} + 4'd1 == r_n) begin
            r_mem_wen <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_cnt       <= w_next;
            r_mem_waddr <= r_addr + {61'd0, w_next};
            r_mem_wdata <= {56'd0, r_wdata[{w_next, 3'b000} +: 8]};
          end
        end
        S_RESP: begin
          if (wb_ready) begin
            r_wb_valid <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
